// File: rtl/counter_seq_checker.sv
// Sink-side checker for a free-running mod-MOD counter: locks onto a clean
// +1 sequence on {Q, qcc}, then flags, counts violations and counts wraps.
module counter_seq_checker #(
    parameter int MOD      = 8,
    parameter int QW       = 4,
    parameter int CW       = 8,
    parameter int LOCK_LEN = 3
) (
    input  logic          cp,
    input  logic          clr,
    input  logic [QW-1:0] Q,
    input  logic          qcc,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] wrap_cnt
);

    localparam int          RW     = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);
    localparam int unsigned MODM1  = MOD - 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);
    localparam logic [RW-1:0] RUN_LEN = RW'(LOCK_LEN);
    localparam logic [QW:0]   EXT_ONE = (QW + 1)'(1);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    state_t        state_q, state_d;
    logic [QW-1:0] q_prev_q, q_prev_d;
    logic [RW-1:0] run_q, run_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [CW-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [QW:0]   q_ext, prev_ext, exp_ext, modm1_ext;
    logic [RW-1:0] run_inc;
    logic          good;
    logic          wrap_step;

    // Step check done one bit wider so q_prev+1 never truncates.
    always_comb begin
        modm1_ext = MODM1[QW:0];
        q_ext     = {1'b0, Q};
        prev_ext  = {1'b0, q_prev_q};
        exp_ext   = (prev_ext == modm1_ext) ? '0 : prev_ext + EXT_ONE;
        good      = (q_ext <= modm1_ext) && (q_ext == exp_ext) &&
                    (qcc == (q_ext == modm1_ext));
        wrap_step = (prev_ext == modm1_ext) && (q_ext == '0);
        run_inc   = run_q + RUN_ONE;
    end

    always_comb begin
        state_d    = state_q;
        q_prev_d   = Q;
        run_d      = run_q;
        locked_d   = locked_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        case (state_q)
            EMPTY: begin
                state_d  = SYNC;
                run_d    = '0;
                locked_d = 1'b0;
            end
            SYNC: begin
                if (good) begin
                    run_d = run_inc;
                    if (run_inc == RUN_LEN) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end else begin
                    run_d = '0;
                end
            end
            LOCKED: begin
                if (good) begin
                    if (wrap_step) wrap_cnt_d = wrap_cnt_q + CNT_ONE;
                end else begin
                    // Resync starts from the violating sample, already in q_prev_d.
                    err_d     = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = SYNC;
                    run_d     = '0;
                    locked_d  = 1'b0;
                end
            end
            default: begin
                state_d  = EMPTY;
                run_d    = '0;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cp or posedge clr) begin
        if (clr) begin
            state_q    <= EMPTY;
            q_prev_q   <= '0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            q_prev_q   <= q_prev_d;
            run_q      <= run_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule
